// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH x 8 byte FIFO that feeds a uart_tx, keeping at most one byte in flight.
// Latency: a byte written into an empty FIFO with tx_idle high gives tx_data_en two edges after the write edge.
// Backpressure: a write while full is dropped and flagged on overflow; pops wait for tx_idle, then for tx_finish.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_data_en,
  output logic [7:0]        tx_data_in,
  input  logic              tx_idle,
  input  logic              tx_finish
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                overflow_q, overflow_d;
  logic                tx_en_q, tx_en_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                push;
  logic                pop;

  // FSM state register; reset returns to IDLE so a flushed FIFO never launches a byte
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: one byte in flight, tx_finish only honoured once the byte is launched
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!empty_q && tx_idle) state_d = SEND;
      SEND:      state_d = WAIT_DONE;
      WAIT_DONE: if (tx_finish) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs: pop the head in IDLE, load the byte, and register the one-cycle load pulse after SEND
  always_comb begin
    pop       = (state_q == IDLE) && !empty_q && tx_idle;
    tx_en_d   = (state_q == SEND);
    tx_data_d = pop ? mem_q[rd_ptr_q] : tx_data_q;
  end

  // FIFO bookkeeping: writes gated only by full, so a same-cycle pop never frees room for a write
  always_comb begin
    push       = wr_en && !full_q;
    overflow_d = wr_en && full_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  // FIFO and output registers; status flags are computed from the next count so they always agree
  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Byte storage; contents need no reset because the pointers and count define validity
  always_ff @(posedge clk_in) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign tx_data_en = tx_en_q;
  assign tx_data_in = tx_data_q;

endmodule
